// File: rtl/ramen_order_feeder.sv
// ramen_order_feeder
//   Upstream stage of the ramen shop core. Orders arrive on a valid/ready
//   port and are buffered in a small FIFO. Each order is then sent to the core
//   as two in_valid beats: the first carries the ramen type, the second the
//   portion. The block waits for the core's per-order result strobe, tallies
//   successes and failures, and closes the selling day after an order flagged
//   last by waiting for the core's day-totals strobe.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   ord_valid/ord_ready        upstream handshake (ready = FIFO not full)
//   ord_type, ord_portion,     order payload, ord_last closes the day
//   ord_last
//   in_valid, selling,         core-facing order protocol (registered)
//   ramen_type, portion
//   out_valid_order, success   per-order result from the core
//   out_valid_tot              day totals strobe from the core
//   day_done                   1-cycle pulse the cycle after totals are seen
//   ok_cnt, fail_cnt           saturating per-day result tallies
module ramen_order_feeder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic [1:0]       ord_type,
  input  logic             ord_portion,
  input  logic             ord_last,
  output logic             in_valid,
  output logic             selling,
  output logic [1:0]       ramen_type,
  output logic             portion,
  input  logic             out_valid_order,
  input  logic             success,
  input  logic             out_valid_tot,
  output logic             day_done,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND0, S_SEND1, S_WAIT, S_HOLD, S_CLOSE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, push, pop;
  logic [3:0]    head;
  logic          cur_portion, cur_last;

  logic          in_valid_d, selling_d, portion_d, day_done_d;
  logic [1:0]    ramen_type_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ord_ready  = (fifo_cnt != DEPTH_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = ord_valid && ord_ready;
  assign pop        = (state == S_SEND0);
  assign head       = fifo_mem[rd_ptr];

  // Entry layout {last, portion, type}. Storage and the in-flight order latch
  // carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {ord_last, ord_portion, ord_type};
    if (pop) begin
      cur_portion <= head[2];
      cur_last    <= head[3];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // State register; core-facing outputs are registered copies of the
  // decode of the current state, so they lag the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_valid   <= 1'b0;
      selling    <= 1'b0;
      ramen_type <= 2'b0;
      portion    <= 1'b0;
      day_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_valid   <= in_valid_d;
      selling    <= selling_d;
      ramen_type <= ramen_type_d;
      portion    <= portion_d;
      day_done   <= day_done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_SEND0;
      S_SEND0: state_nxt = S_SEND1;
      S_SEND1: state_nxt = S_WAIT;
      S_WAIT: begin
        if (out_valid_order) begin
          if (cur_last)         state_nxt = S_CLOSE;
          else if (!fifo_empty) state_nxt = S_SEND0;
          else                  state_nxt = S_HOLD;
        end
      end
      S_HOLD:  if (!fifo_empty) state_nxt = S_SEND0;
      S_CLOSE: if (out_valid_tot) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_valid_d   = (state == S_SEND0) || (state == S_SEND1);
    selling_d    = (state == S_SEND0) || (state == S_SEND1) ||
                   (state == S_WAIT)  || (state == S_HOLD);
    ramen_type_d = (state == S_SEND0) ? head[1:0] : 2'b0;
    portion_d    = (state == S_SEND1) ? cur_portion : 1'b0;
    // Totals are only honoured while the day is closing.
    day_done_d   = (state == S_CLOSE) && out_valid_tot;
  end

  // Tallies clear when a new day starts and hold after day_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= '0;
      fail_cnt <= '0;
    end else if ((state == S_IDLE) && !fifo_empty) begin
      ok_cnt   <= '0;
      fail_cnt <= '0;
    end else if ((state == S_WAIT) && out_valid_order) begin
      if (success) ok_cnt   <= sat_inc(ok_cnt);
      else         fail_cnt <= sat_inc(fail_cnt);
    end
  end

endmodule

// File: tb/tb_ramen_order_feeder.sv
// tb_ramen_order_feeder
//   Randomized bench for ramen_order_feeder. A behavioural model (order queue
//   plus a description of the day in terms of phases) predicts every output
//   each cycle; a core emulator answers in_valid beats with result strobes and
//   closes days with totals. Directed sections pin literal values.
module tb_ramen_order_feeder;
  localparam int DEPTH = 8;
  localparam int CNT_W = 7;
  localparam int M_IDLE = 0, M_SEND0 = 1, M_SEND1 = 2, M_WAIT = 3, M_HOLD = 4, M_CLOSE = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic ord_valid, ord_ready, ord_portion, ord_last;
  logic [1:0] ord_type;
  logic in_valid, selling, portion;
  logic [1:0] ramen_type;
  logic out_valid_order, success, out_valid_tot, day_done;
  logic [CNT_W-1:0] ok_cnt, fail_cnt;

  always #5 clk = ~clk;

  ramen_order_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_type(ord_type),
    .ord_portion(ord_portion), .ord_last(ord_last),
    .in_valid(in_valid), .selling(selling), .ramen_type(ramen_type), .portion(portion),
    .out_valid_order(out_valid_order), .success(success), .out_valid_tot(out_valid_tot),
    .day_done(day_done), .ok_cnt(ok_cnt), .fail_cnt(fail_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: pending orders {last,portion,type}, day phase, order in flight.
  logic [3:0] mq[$];
  int ph;
  bit m_por, m_last;
  int m_ok, m_fail;
  int e_iv, e_sel, e_type, e_por, e_dd;

  // Stimulus control.
  logic [3:0] src[$];
  bit succ_pat[$];
  int offer_pct = 100, succ_pct = 100, max_extra = 0, strobe_budget = -1;
  bit noise = 0, held = 0, release_rst = 0;
  int wt_age = 0, cl_age = 0, wt_extra = 0, cl_extra = 0, dd_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    ph = M_IDLE;
    m_ok = 0; m_fail = 0;
    e_iv = 0; e_sel = 0; e_type = 0; e_por = 0; e_dd = 0;
  endfunction

  function automatic void model_step(bit ovo, bit succ, bit ovt, bit acc, logic [3:0] ent);
    logic [3:0] popped;
    int sat;
    bit avail;
    sat   = (1 << CNT_W) - 1;
    avail = (mq.size() > 0);
    // What the core sees next cycle follows from the phase of this cycle.
    e_iv   = (ph == M_SEND0 || ph == M_SEND1) ? 1 : 0;
    e_sel  = (ph == M_SEND0 || ph == M_SEND1 || ph == M_WAIT || ph == M_HOLD) ? 1 : 0;
    e_type = (ph == M_SEND0) ? int'(mq[0][1:0]) : 0;
    e_por  = (ph == M_SEND1) ? int'(m_por) : 0;
    e_dd   = (ph == M_CLOSE && ovt) ? 1 : 0;
    case (ph)
      M_IDLE: if (avail) begin m_ok = 0; m_fail = 0; ph = M_SEND0; end
      M_SEND0: begin
        popped = mq.pop_front();
        m_por = popped[2]; m_last = popped[3];
        ph = M_SEND1;
      end
      M_SEND1: ph = M_WAIT;
      M_WAIT: if (ovo) begin
        if (succ) m_ok = (m_ok < sat) ? m_ok + 1 : m_ok;
        else      m_fail = (m_fail < sat) ? m_fail + 1 : m_fail;
        if (m_last)     ph = M_CLOSE;
        else if (avail) ph = M_SEND0;
        else            ph = M_HOLD;
      end
      M_HOLD:  if (avail) ph = M_SEND0;
      M_CLOSE: if (ovt) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    if (acc) mq.push_back(ent);
  endfunction

  task automatic check_outputs();
    chk("ord_ready", int'(ord_ready), (mq.size() < DEPTH) ? 1 : 0);
    chk("in_valid", int'(in_valid), e_iv);
    chk("selling", int'(selling), e_sel);
    chk("ramen_type", int'(ramen_type), e_type);
    chk("portion", int'(portion), e_por);
    chk("day_done", int'(day_done), e_dd);
    chk("ok_cnt", int'(ok_cnt), m_ok);
    chk("fail_cnt", int'(fail_cnt), m_fail);
  endtask

  // One clock cycle: compare at the falling edge, then drive the next inputs
  // and advance the model across the coming rising edge.
  task automatic tick();
    bit ovo, succ, ovt, acc;
    logic [3:0] ent;
    @(negedge clk);
    check_outputs();
    if (day_done === 1'b1) dd_seen++;
    ovo = 0; ovt = 0; succ = 1'($urandom_range(1));
    if (ph == M_WAIT) begin
      wt_age++;
      if (strobe_budget != 0 && wt_age >= 2 + wt_extra) begin
        ovo = 1;
        if (succ_pat.size() > 0) succ = succ_pat.pop_front();
        else succ = ($urandom_range(99) < succ_pct);
        wt_extra = $urandom_range(max_extra);
        if (strobe_budget > 0) strobe_budget--;
      end
    end else begin
      wt_age = 0;
      if (noise && $urandom_range(9) == 0) ovo = 1;
    end
    if (ph == M_CLOSE) begin
      cl_age++;
      if (cl_age >= 2 + cl_extra) begin
        ovt = 1;
        cl_extra = $urandom_range(max_extra);
      end
    end else begin
      cl_age = 0;
      if (noise && $urandom_range(9) == 0) ovt = 1;
    end
    if (!held) begin
      if (src.size() > 0 && $urandom_range(99) < offer_pct) begin
        ord_valid = 1'b1; ent = src[0];
      end else begin
        ord_valid = 1'b0; ent = 4'($urandom);
      end
      {ord_last, ord_portion, ord_type} = ent;
    end
    ent = {ord_last, ord_portion, ord_type};
    if (release_rst) begin rst_n = 1'b1; release_rst = 0; end
    acc  = ord_valid && (mq.size() < DEPTH) && rst_n;
    held = ord_valid && !acc && rst_n;
    if (acc) void'(src.pop_front());
    out_valid_order = ovo; success = succ; out_valid_tot = ovt;
    if (rst_n) model_step(ovo, succ, ovt, acc, ent);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((src.size() > 0 || ph != M_IDLE || mq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < budget) ? 1 : 0, 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dd0;
    logic [3:0] e;
    rst_n = 1'b0; ord_valid = 0; ord_type = 0; ord_portion = 0; ord_last = 0;
    out_valid_order = 0; success = 0; out_valid_tot = 0;
    model_reset();
    tick(); tick();
    chk("reset_ord_ready", int'(ord_ready), 1);
    chk("reset_in_valid", int'(in_valid), 0);
    chk("reset_selling", int'(selling), 0);
    chk("reset_ok_cnt", int'(ok_cnt), 0);
    release_rst = 1;
    tick();

    // Single order {type 2, big, last}: exact cycle-by-cycle behaviour.
    src.push_back(4'b1110); succ_pat.push_back(1'b1);
    tick(); tick(); tick();
    chk("t1_no_beat_yet", int'(in_valid), 0);
    tick();
    chk("t1_beat1_valid", int'(in_valid), 1);
    chk("t1_beat1_type", int'(ramen_type), 2);
    chk("t1_beat1_selling", int'(selling), 1);
    tick();
    chk("t1_beat2_valid", int'(in_valid), 1);
    chk("t1_beat2_portion", int'(portion), 1);
    chk("t1_beat2_type", int'(ramen_type), 0);
    tick();
    chk("t1_wait_valid", int'(in_valid), 0);
    tick();
    chk("t1_ok_cnt", int'(ok_cnt), 1);
    chk("t1_selling_tail", int'(selling), 1);
    tick();
    chk("t1_selling_drop", int'(selling), 0);
    tick();
    chk("t1_day_done", int'(day_done), 1);
    tick();
    chk("t1_day_done_pulse", int'(day_done), 0);
    chk("t1_ok_hold", int'(ok_cnt), 1);

    // Three back-to-back orders, last on the third.
    dd0 = dd_seen;
    src.push_back(4'b0000); src.push_back(4'b0001); src.push_back(4'b1011);
    run_until_idle(200);
    chk("t2_ok_cnt", int'(ok_cnt), 3);
    chk("t2_fail_cnt", int'(fail_cnt), 0);
    chk("t2_one_day_done", dd_seen - dd0, 1);

    // Core stalled: fill the FIFO, the ninth waits for a pop.
    strobe_budget = 0;
    src.push_back(4'b0001);
    n = 0;
    while (ph != M_WAIT && n < 20) begin tick(); n++; end
    chk("t3_reach_wait", (n < 20) ? 1 : 0, 1);
    for (int i = 0; i < 9; i++) begin
      e = {1'(i == 8), 1'(i % 2), 2'(i)};
      src.push_back(e);
    end
    n = 0;
    while (mq.size() < DEPTH && n < 40) begin tick(); n++; end
    tick();
    chk("t3_full_ready", int'(ord_ready), 0);
    chk("t3_ninth_blocked", src.size(), 1);
    tick(); tick();
    chk("t3_still_full", int'(ord_ready), 0);
    strobe_budget = -1;
    run_until_idle(300);

    // Gap between orders: HOLD keeps the day open with no beats.
    src.push_back(4'b0010);
    n = 0;
    while (ph != M_HOLD && n < 30) begin tick(); n++; end
    chk("t4_reach_hold", (n < 30) ? 1 : 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_gap_selling", int'(selling), 1);
      chk("t4_gap_in_valid", int'(in_valid), 0);
    end
    src.push_back(4'b1101);
    run_until_idle(100);
    chk("t4_closed", int'(selling), 0);

    // Mixed results, then the next day clears the tallies.
    succ_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    src.push_back(4'b0011); src.push_back(4'b0100); src.push_back(4'b0110); src.push_back(4'b1001);
    run_until_idle(200);
    chk("t5_ok_cnt", int'(ok_cnt), 2);
    chk("t5_fail_cnt", int'(fail_cnt), 2);
    succ_pat.push_back(1'b0);
    src.push_back(4'b1000);
    n = 0;
    while (ph != M_SEND0 && n < 20) begin tick(); n++; end
    tick();
    chk("t5_clear_ok", int'(ok_cnt), 0);
    chk("t5_clear_fail", int'(fail_cnt), 0);
    run_until_idle(100);
    chk("t5_next_fail", int'(fail_cnt), 1);

    // Asynchronous reset while waiting for a result.
    strobe_budget = 2; succ_pat.delete(); succ_pct = 100;
    for (int i = 0; i < 5; i++) src.push_back(4'(i));
    n = 0;
    while (!(ph == M_WAIT && m_ok == 2) && n < 60) begin tick(); n++; end
    tick();
    chk("t6_pre_reset_ok", int'(ok_cnt), 2);
    chk("t6_pre_reset_selling", int'(selling), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_in_valid", int'(in_valid), 0);
    chk("t6_rst_selling", int'(selling), 0);
    chk("t6_rst_ok_cnt", int'(ok_cnt), 0);
    chk("t6_rst_ord_ready", int'(ord_ready), 1);
    model_reset(); src.delete(); held = 0; ord_valid = 0;
    strobe_budget = -1; wt_age = 0; cl_age = 0;
    tick(); tick();
    release_rst = 1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t6_fifo_empty_no_beat", int'(in_valid), 0);
    chk("t6_fifo_empty_selling", int'(selling), 0);

    // Randomized traffic with stray strobes, sparse then dense arrivals.
    noise = 1; offer_pct = 40; succ_pct = 70; max_extra = 3;
    for (int i = 0; i < 60; i++) begin
      e = 4'($urandom);
      e[3] = ($urandom_range(4) == 0) || (i == 59);
      src.push_back(e);
    end
    run_until_idle(5000);
    offer_pct = 90; max_extra = 6;
    for (int i = 0; i < 60; i++) begin
      e = 4'($urandom);
      e[3] = ($urandom_range(6) == 0) || (i == 59);
      src.push_back(e);
    end
    run_until_idle(8000);

    // One long day: the success tally saturates.
    noise = 0; offer_pct = 100; succ_pct = 100; max_extra = 0; wt_extra = 0; cl_extra = 0;
    for (int i = 0; i < 130; i++) begin
      e = {1'b0, 1'($urandom), 2'($urandom)};
      src.push_back(e);
    end
    src.push_back(4'b1000);
    run_until_idle(2000);
    chk("sat_ok_cnt", int'(ok_cnt), 127);
    chk("sat_fail_cnt", int'(fail_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
